coeff_load_sched: RTL and testbench

//  Sequences a full 5x5 coefficient reload into axi_data2coeff from a coefficient-set BRAM.

---
 rtl/coeff_load_sched_pkg.sv | 42 ++++
 rtl/coeff_load_sched_if.sv | 54 +++++
 rtl/coeff_load_sched_wr_arbiter.sv | 49 ++++
 rtl/coeff_load_sched.sv | 130 +++++++++++++
 tb/tb_coeff_load_sched.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coeff_load_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coeff_load_sched_pkg
//  Description : Shared constants, FSM state encoding and small helpers for
//                the coefficient-set reload sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package coeff_load_sched_pkg;

   localparam int NUM_COEFF        = 25;              // 5x5 coefficient set
   localparam int BANK_W           = 2;               // bank-select width
   localparam int DATA_W           = 32;              // BRAM word / write-data width
   localparam int ADDR_W           = 8;               // byte address of write port
   localparam int COEFF_W          = 16;              // coefficient lives in [15:0]
   localparam int IDX_W            = 5;               // word index within a bank
   localparam int STRB_W           = 4;               // byte strobes per word
   localparam int BRAM_AW          = BANK_W + IDX_W;  // {bank, idx}
   localparam int BANK_WORD_STRIDE = 32;              // words per bank slot
   localparam int BYTE_STRIDE      = 4;               // bytes per coefficient register
   localparam int SUM_W            = 21;              // checksum accumulator width

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_FRAME = 3'd1,
      ST_READ       = 3'd2,
      ST_CAPTURE    = 3'd3,
      ST_WRITE      = 3'd4,
      ST_DONE       = 3'd5
   } state_t;

   // Byte address of coefficient register idx (idx * BYTE_STRIDE).
   function automatic logic [ADDR_W-1:0] coeff_byte_addr(input logic [IDX_W-1:0] idx);
      return {{(ADDR_W-IDX_W-2){1'b0}}, idx, 2'b00};
   endfunction

   // Sign-extend the coefficient field of a BRAM word to accumulator width.
   function automatic logic signed [SUM_W-1:0] coeff_sext(input logic [DATA_W-1:0] word);
      return {{(SUM_W-COEFF_W){word[COEFF_W-1]}}, word[COEFF_W-1:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/coeff_load_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : coeff_load_sched_if
//  Description : Control, BRAM and coefficient write-port bundle of the
//                reload sequencer. coeff_sum exists only when
//                COEFF_LOAD_CHECKSUM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface coeff_load_sched_if;
   import coeff_load_sched_pkg::*;

   logic                start;
   logic [BANK_W-1:0]   bank_sel;
   logic                frame_busy;
   logic                hold_frame;
   logic                busy;
   logic                done;
   logic                bram_en;
   logic [BRAM_AW-1:0]  bram_addr;
   logic [DATA_W-1:0]   bram_rdata;
   logic [ADDR_W-1:0]   cpu_wr_addr;
   logic                cpu_wr_en;
   logic [DATA_W-1:0]   cpu_wr_data;
   logic [STRB_W-1:0]   cpu_wr_strb;
   logic [ADDR_W-1:0]   wr_addr;
   logic                wr_en;
   logic [DATA_W-1:0]   wr_data;
   logic [STRB_W-1:0]   wr_strb;
`ifdef COEFF_LOAD_CHECKSUM_EN
   logic [SUM_W-1:0]    coeff_sum;
`endif

   modport slave (
      input  start, bank_sel, frame_busy, bram_rdata,
             cpu_wr_addr, cpu_wr_en, cpu_wr_data, cpu_wr_strb,
      output hold_frame, busy, done, bram_en, bram_addr,
             wr_addr, wr_en, wr_data, wr_strb
`ifdef COEFF_LOAD_CHECKSUM_EN
      , output coeff_sum
`endif
   );

   modport master (
      output start, bank_sel, frame_busy, bram_rdata,
             cpu_wr_addr, cpu_wr_en, cpu_wr_data, cpu_wr_strb,
      input  hold_frame, busy, done, bram_en, bram_addr,
             wr_addr, wr_en, wr_data, wr_strb
`ifdef COEFF_LOAD_CHECKSUM_EN
      , input coeff_sum
`endif
   );

endinterface
`default_nettype wire

// File: rtl/coeff_load_sched_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : coeff_wr_arbiter
//  Description : Registerless 2:1 priority mux onto the coefficient write
//                port. The CPU always wins; the loader is granted only when
//                it requests and the CPU is silent. Port is all-zero when
//                neither side drives it.
//  Revision    : 1.0 - initial release
// ============================================================================
module coeff_wr_arbiter
   import coeff_load_sched_pkg::*;
(
   input  logic                cpu_wr_en_i,
   input  logic [ADDR_W-1:0]   cpu_wr_addr_i,
   input  logic [DATA_W-1:0]   cpu_wr_data_i,
   input  logic [STRB_W-1:0]   cpu_wr_strb_i,
   input  logic                ld_req_i,
   input  logic [ADDR_W-1:0]   ld_addr_i,
   input  logic [DATA_W-1:0]   ld_data_i,
   input  logic [STRB_W-1:0]   ld_strb_i,
   output logic                wr_en_o,
   output logic [ADDR_W-1:0]   wr_addr_o,
   output logic [DATA_W-1:0]   wr_data_o,
   output logic [STRB_W-1:0]   wr_strb_o,
   output logic                loader_gnt_o
);

   // Priority select: CPU first, loader second, otherwise idle zeros.
   always_comb begin
      wr_en_o      = 1'b0;
      wr_addr_o    = '0;
      wr_data_o    = '0;
      wr_strb_o    = '0;
      loader_gnt_o = ld_req_i & ~cpu_wr_en_i;
      if (cpu_wr_en_i) begin
         wr_en_o   = 1'b1;
         wr_addr_o = cpu_wr_addr_i;
         wr_data_o = cpu_wr_data_i;
         wr_strb_o = cpu_wr_strb_i;
      end else if (ld_req_i) begin
         wr_en_o   = 1'b1;
         wr_addr_o = ld_addr_i;
         wr_data_o = ld_data_i;
         wr_strb_o = ld_strb_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/coeff_load_sched.sv
`default_nettype none
// ============================================================================
//  Module      : coeff_load_sched
//  Description : Reloads a full 5x5 coefficient set from a banked BRAM into
//                axi_data2coeff between frames, sharing the write port with
//                MicroBlaze (CPU has priority). Holds off new frames while
//                busy. Optional feature macro COEFF_LOAD_CHECKSUM_EN adds a
//                signed running sum of the loaded coefficients (coeff_sum).
//  Revision    : 1.0 - initial release
// ============================================================================
module coeff_load_sched
   import coeff_load_sched_pkg::*;
(
   input  logic               microblaze_clk,
   input  logic               rst_n,
   coeff_load_sched_if.slave  bus
);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q,   idx_d;
   logic [BANK_W-1:0]    bank_q,  bank_d;
   logic [DATA_W-1:0]    hold_q,  hold_d;
   logic                 ld_req;
   logic                 ld_gnt;
   logic                 rd_en;

   // Loader request and BRAM read strobe are pure state decodes.
   assign ld_req = (state_q == ST_WRITE);
   assign rd_en  = (state_q == ST_READ);

   // State and datapath registers.
   always_ff @(posedge microblaze_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         bank_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         bank_q  <= bank_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state logic; a CPU write in WRITE defers the loader write by a cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      bank_d  = bank_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               bank_d  = bus.bank_sel;
               idx_d   = '0;
               state_d = ST_WAIT_FRAME;
            end
         end
         ST_WAIT_FRAME: begin
            if (!bus.frame_busy) state_d = ST_READ;
         end
         ST_READ: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            hold_d  = bus.bram_rdata;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (ld_gnt) begin
               idx_d   = idx_q + 1'b1;
               state_d = (idx_q == IDX_W'(NUM_COEFF-1)) ? ST_DONE : ST_READ;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.hold_frame = (state_q != ST_IDLE);
   assign bus.done       = (state_q == ST_DONE);
   assign bus.bram_en    = rd_en;
   assign bus.bram_addr  = rd_en ? {bank_q, idx_q} : '0;

   coeff_wr_arbiter u_arb (
      .cpu_wr_en_i   (bus.cpu_wr_en),
      .cpu_wr_addr_i (bus.cpu_wr_addr),
      .cpu_wr_data_i (bus.cpu_wr_data),
      .cpu_wr_strb_i (bus.cpu_wr_strb),
      .ld_req_i      (ld_req),
      .ld_addr_i     (coeff_byte_addr(idx_q)),
      .ld_data_i     (hold_q),
      .ld_strb_i     ({STRB_W{1'b1}}),
      .wr_en_o       (bus.wr_en),
      .wr_addr_o     (bus.wr_addr),
      .wr_data_o     (bus.wr_data),
      .wr_strb_o     (bus.wr_strb),
      .loader_gnt_o  (ld_gnt)
   );

`ifdef COEFF_LOAD_CHECKSUM_EN
   logic signed [SUM_W-1:0] sum_q, sum_d;

   // Checksum next value: cleared on accepted start, accumulates granted writes.
   always_comb begin
      sum_d = sum_q;
      if ((state_q == ST_IDLE) && bus.start) begin
         sum_d = '0;
      end else if (ld_gnt) begin
         sum_d = sum_q + coeff_sext(hold_q);
      end
   end

   // Checksum accumulator register.
   always_ff @(posedge microblaze_clk or negedge rst_n) begin
      if (!rst_n) sum_q <= '0;
      else        sum_q <= sum_d;
   end

   assign bus.coeff_sum = sum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coeff_load_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coeff_load_sched
//  Description : Directed self-checking bench for coeff_load_sched, with a
//                BRAM model and an axi_data2coeff register model. Checksum
//                checks follow COEFF_LOAD_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coeff_load_sched;
   import coeff_load_sched_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   coeff_load_sched_if bus_if();

   coeff_load_sched dut (
      .microblaze_clk (clk),
      .rst_n          (rst_n),
      .bus            (bus_if.slave)
   );

   typedef struct {
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      int          c;
   } wr_t;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          done_cyc = 0;
   int          done_cnt = 0;
   wr_t         log_q[$];
   int          bram_q[$];
   logic [31:0] mem [0:127];
   logic [15:0] coeff_reg [0:24];

   function automatic logic [31:0] bank_word(input int b, input int i);
      case (b)
         0:       return 32'(i * 3);
         1:       return 32'(i + 10);
         2:       return 32'(200 + 2 * i);
         default: return {16'h5A5A, 16'(-(i + 1))};
      endcase
   endfunction

   // BRAM model: one-cycle read latency.
   always @(posedge clk) begin
      if (bus_if.bram_en) bus_if.bram_rdata <= mem[bus_if.bram_addr];
   end

   // Cycle counter, write-port/coefficient-register model and event log.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus_if.wr_en) begin
         log_q.push_back('{bus_if.wr_addr, bus_if.wr_data, bus_if.wr_strb, cyc});
         if (bus_if.wr_addr < 8'd100) coeff_reg[int'(bus_if.wr_addr[7:2])] <= bus_if.wr_data[15:0];
      end
      if (bus_if.bram_en) bram_q.push_back(cyc);
      if (bus_if.done) begin
         done_cyc <= cyc;
         done_cnt <= done_cnt + 1;
      end
   end

   // Start is presented on a negedge; k is the cycle stamp of the sampling edge.
   task automatic do_start(input logic [1:0] b, output int k);
      @(negedge clk);
      k = cyc;
      bus_if.bank_sel = b;
      bus_if.start    = 1'b1;
      @(negedge clk);
      bus_if.start    = 1'b0;
   endtask

   task automatic wait_done(input int budget, output logic ok);
      int c0;
      c0 = done_cnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_cnt != c0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_if.start = 1'b0; bus_if.bank_sel = '0; bus_if.frame_busy = 1'b0;
      bus_if.cpu_wr_en = 1'b0; bus_if.cpu_wr_addr = '0; bus_if.cpu_wr_data = '0; bus_if.cpu_wr_strb = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus_if.wr_en, bus_if.bram_en, bus_if.busy, bus_if.done, bus_if.hold_frame} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: wr_en/bram_en/busy/done/hold_frame=%b, required 00000",
                  {bus_if.wr_en, bus_if.bram_en, bus_if.busy, bus_if.done, bus_if.hold_frame});
      end
      n_cmp++;
      if ({bus_if.wr_addr, bus_if.wr_data, bus_if.wr_strb, bus_if.bram_addr} !== '0) begin
         n_err++;
         $display("FAIL reset_bus: addr=%h data=%h strb=%h bram_addr=%h, required all 0",
                  bus_if.wr_addr, bus_if.wr_data, bus_if.wr_strb, bus_if.bram_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus_if.busy !== 1'b0 || bus_if.hold_frame !== 1'b0 || bus_if.wr_en !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: busy=%b hold_frame=%b wr_en=%b, required 0/0/0",
                  bus_if.busy, bus_if.hold_frame, bus_if.wr_en);
      end
   endtask

   task automatic test_basic_load();
      int k, base, bad;
      logic ok;
      wr_t w;
      base = log_q.size();
      do_start(2'd1, k);
      n_cmp++;
      if (bus_if.hold_frame !== 1'b1 || bus_if.busy !== 1'b1) begin
         n_err++;
         $display("FAIL basic_hold_frame: hold_frame=%b busy=%b, required 1/1", bus_if.hold_frame, bus_if.busy);
      end
      wait_done(200, ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_err++; $display("FAIL basic_timeout: done=0 after 200 cycles, required done"); end
      n_cmp++;
      if (log_q.size() - base != 25) begin n_err++; $display("FAIL basic_count: writes=%0d, required 25", log_q.size() - base); end
      n_cmp++;
      if (done_cyc - k != 77) begin n_err++; $display("FAIL basic_done_lat: %0d, required 77", done_cyc - k); end
      for (int i = 0; i < 25; i++) begin
         if (base + i < log_q.size()) begin
            w = log_q[base + i];
            n_cmp++;
            if (w.a !== 8'(4 * i) || w.d !== 32'(i + 10) || w.s !== 4'hF || w.c - k != 4 + 3 * i) begin
               n_err++;
               $display("FAIL basic_wr%0d: addr=%h data=%h strb=%h lat=%0d, required %h %h F %0d",
                        i, w.a, w.d, w.s, w.c - k, 8'(4 * i), 32'(i + 10), 4 + 3 * i);
            end
         end
      end
      bad = 0;
      for (int i = 0; i < 25; i++) if (coeff_reg[i] !== 16'(i + 10)) bad++;
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL basic_coeff_regs: %0d wrong, required 0 (coeff = 10..34)", bad); end
`ifdef COEFF_LOAD_CHECKSUM_EN
      n_cmp++;
      if (bus_if.coeff_sum !== 21'(550)) begin
         n_err++; $display("FAIL basic_checksum: %0d, required 550", $signed(bus_if.coeff_sum));
      end
`endif
      @(negedge clk);
      n_cmp++;
      if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_after: busy=%b, required 0", bus_if.busy); end
   endtask

   task automatic test_frame_busy();
      int k, base, bbase;
      logic ok, early;
      wr_t w;
      base  = log_q.size();
      bbase = bram_q.size();
      early = 1'b0;
      bus_if.frame_busy = 1'b1;
      do_start(2'd3, k);
      n_cmp++;
      if (bus_if.hold_frame !== 1'b1) begin n_err++; $display("FAIL fb_hold_frame: %b, required 1", bus_if.hold_frame); end
      if (bus_if.bram_en !== 1'b0) early = 1'b1;
      for (int n = 2; n <= 21; n++) begin
         @(negedge clk);
         if (bus_if.bram_en !== 1'b0) early = 1'b1;
         if (n == 21) bus_if.frame_busy = 1'b0;
      end
      n_cmp++;
      if (early !== 1'b0) begin n_err++; $display("FAIL fb_no_early_read: bram_en seen=%b, required 0", early); end
      wait_done(200, ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_err++; $display("FAIL fb_timeout: done=0 after 200 cycles, required done"); end
      n_cmp++;
      if (bram_q.size() <= bbase || bram_q[bbase] - k != 22) begin
         n_err++; $display("FAIL fb_first_read: reads=%0d, required first read at latency 22", bram_q.size() - bbase);
      end
      n_cmp++;
      if (done_cyc - k != 97) begin n_err++; $display("FAIL fb_done_lat: %0d, required 97", done_cyc - k); end
      n_cmp++;
      if (log_q.size() - base != 25) begin n_err++; $display("FAIL fb_count: writes=%0d, required 25", log_q.size() - base); end
      for (int i = 0; i < 25; i++) begin
         if (base + i < log_q.size()) begin
            w = log_q[base + i];
            n_cmp++;
            if (w.a !== 8'(4 * i) || w.d !== bank_word(3, i)) begin
               n_err++;
               $display("FAIL fb_wr%0d: addr=%h data=%h, required %h %h", i, w.a, w.d, 8'(4 * i), bank_word(3, i));
            end
         end
      end
`ifdef COEFF_LOAD_CHECKSUM_EN
      n_cmp++;
      if (bus_if.coeff_sum !== 21'(-325)) begin
         n_err++; $display("FAIL fb_checksum: %0d, required -325", $signed(bus_if.coeff_sum));
      end
`endif
   endtask

   task automatic test_cpu_contention();
      int k, base, li;
      logic ok;
      wr_t w;
      @(negedge clk);
      bus_if.cpu_wr_en = 1'b1; bus_if.cpu_wr_addr = 8'hF0; bus_if.cpu_wr_data = 32'hCAFE_0001; bus_if.cpu_wr_strb = 4'h5;
      #1;
      n_cmp++;
      if ({bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data, bus_if.wr_strb} !== {1'b1, 8'hF0, 32'hCAFE_0001, 4'h5}) begin
         n_err++;
         $display("FAIL cpu_idle_pass: en=%b addr=%h data=%h strb=%h, required 1 f0 cafe0001 5",
                  bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data, bus_if.wr_strb);
      end
      @(negedge clk);
      bus_if.cpu_wr_en = 1'b0; bus_if.cpu_wr_addr = '0; bus_if.cpu_wr_data = '0; bus_if.cpu_wr_strb = '0;
      base = log_q.size();
      do_start(2'd0, k);
      for (int n = 2; n <= 20; n++) begin
         @(negedge clk);
         if (n == 19) begin
            bus_if.cpu_wr_en = 1'b1; bus_if.cpu_wr_addr = 8'hF0; bus_if.cpu_wr_data = 32'h1234_5678; bus_if.cpu_wr_strb = 4'h3;
            #1;
            n_cmp++;
            if ({bus_if.wr_addr, bus_if.wr_data, bus_if.wr_strb} !== {8'hF0, 32'h1234_5678, 4'h3}) begin
               n_err++;
               $display("FAIL cpu_win: addr=%h data=%h strb=%h, required f0 12345678 3",
                        bus_if.wr_addr, bus_if.wr_data, bus_if.wr_strb);
            end
         end
         if (n == 20) begin
            bus_if.cpu_wr_en = 1'b0; bus_if.cpu_wr_addr = '0; bus_if.cpu_wr_data = '0; bus_if.cpu_wr_strb = '0;
         end
      end
      wait_done(200, ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_err++; $display("FAIL cpu_timeout: done=0 after 200 cycles, required done"); end
      n_cmp++;
      if (done_cyc - k != 78) begin n_err++; $display("FAIL cpu_done_lat: %0d, required 78", done_cyc - k); end
      n_cmp++;
      if (log_q.size() - base != 26) begin n_err++; $display("FAIL cpu_count: writes=%0d, required 26", log_q.size() - base); end
      for (int j = 0; j < 26; j++) begin
         if (base + j < log_q.size()) begin
            w = log_q[base + j];
            n_cmp++;
            if (j == 5) begin
               if (w.a !== 8'hF0 || w.d !== 32'h1234_5678 || w.c - k != 19) begin
                  n_err++;
                  $display("FAIL cpu_slot: addr=%h data=%h lat=%0d, required f0 12345678 19", w.a, w.d, w.c - k);
               end
            end else begin
               li = (j < 5) ? j : j - 1;
               if (w.a !== 8'(4 * li) || w.d !== 32'(3 * li) || w.s !== 4'hF ||
                   w.c - k != ((j < 5) ? 4 + 3 * li : 5 + 3 * li)) begin
                  n_err++;
                  $display("FAIL cpu_ld_wr%0d: addr=%h data=%h lat=%0d, required %h %h %0d", li, w.a, w.d, w.c - k,
                           8'(4 * li), 32'(3 * li), (j < 5) ? 4 + 3 * li : 5 + 3 * li);
               end
            end
         end
      end
`ifdef COEFF_LOAD_CHECKSUM_EN
      n_cmp++;
      if (bus_if.coeff_sum !== 21'(900)) begin
         n_err++; $display("FAIL cpu_checksum: %0d, required 900", $signed(bus_if.coeff_sum));
      end
`endif
   endtask

   task automatic test_back_to_back();
      int k, base, bad;
      logic ok;
      base = log_q.size();
      do_start(2'd3, k);
      for (int n = 2; n <= 80; n++) begin
         @(negedge clk);
         if (n == 30) begin bus_if.start = 1'b1; bus_if.bank_sel = 2'd2; end
         if (n == 31) bus_if.start = 1'b0;
         if (n == 77) begin
            n_cmp++;
            if (bus_if.done !== 1'b1) begin n_err++; $display("FAIL b2b_done_cycle: done=%b, required 1", bus_if.done); end
            bus_if.start = 1'b1; bus_if.bank_sel = 2'd2;
         end
         if (n == 78) bus_if.start = 1'b0;
      end
      n_cmp++;
      if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL b2b_start_at_done: busy=%b, required 0", bus_if.busy); end
      n_cmp++;
      if (log_q.size() - base != 25) begin n_err++; $display("FAIL b2b_count: writes=%0d, required 25", log_q.size() - base); end
      bad = 0;
      for (int i = 0; i < 25; i++) if (base + i >= log_q.size() || log_q[base + i].d !== bank_word(3, i)) bad++;
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL b2b_first_data: %0d wrong words, required 0", bad); end
      base = log_q.size();
      do_start(2'd2, k);
      wait_done(200, ok);
      n_cmp++;
      if (ok !== 1'b1 || done_cyc - k != 77) begin
         n_err++; $display("FAIL b2b_second_done: ok=%b lat=%0d, required 1 77", ok, done_cyc - k);
      end
      bad = 0;
      for (int i = 0; i < 25; i++)
         if (base + i >= log_q.size() || log_q[base + i].d !== 32'(200 + 2 * i) || log_q[base + i].a !== 8'(4 * i)) bad++;
      n_cmp++;
      if (bad != 0 || log_q.size() - base != 25) begin
         n_err++; $display("FAIL b2b_second_data: %0d wrong of %0d writes, required 0 of 25", bad, log_q.size() - base);
      end
`ifdef COEFF_LOAD_CHECKSUM_EN
      n_cmp++;
      if (bus_if.coeff_sum !== 21'(5600)) begin
         n_err++; $display("FAIL b2b_checksum: %0d, required 5600", $signed(bus_if.coeff_sum));
      end
`endif
   endtask

   task automatic test_reset_mid();
      int k, base, bad;
      logic ok;
      base = log_q.size();
      do_start(2'd1, k);
      for (int n = 2; n <= 34; n++) @(negedge clk);
      n_cmp++;
      if (bus_if.wr_en !== 1'b1 || bus_if.wr_addr !== 8'd40) begin
         n_err++; $display("FAIL rstmid_pre: wr_en=%b addr=%h, required 1 28", bus_if.wr_en, bus_if.wr_addr);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus_if.wr_en, bus_if.bram_en, bus_if.busy, bus_if.hold_frame, bus_if.done} !== 5'b0) begin
         n_err++;
         $display("FAIL rstmid_async: wr_en/bram_en/busy/hold/done=%b, required 00000",
                  {bus_if.wr_en, bus_if.bram_en, bus_if.busy, bus_if.hold_frame, bus_if.done});
      end
      n_cmp++;
      if (log_q.size() - base != 10) begin n_err++; $display("FAIL rstmid_partial: writes=%0d, required 10", log_q.size() - base); end
      @(negedge clk);
      rst_n = 1'b1;
      base = log_q.size();
      do_start(2'd0, k);
      wait_done(200, ok);
      n_cmp++;
      if (ok !== 1'b1 || done_cyc - k != 77 || log_q.size() - base != 25) begin
         n_err++;
         $display("FAIL rstmid_reload: ok=%b lat=%0d writes=%0d, required 1 77 25", ok, done_cyc - k, log_q.size() - base);
      end
      bad = 0;
      for (int i = 0; i < 25; i++) if (coeff_reg[i] !== 16'(3 * i)) bad++;
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL rstmid_coeff_regs: %0d wrong, required 0", bad); end
   endtask

   initial begin
      for (int a = 0; a < 128; a++) mem[a] = ((a % 32) < 25) ? bank_word(a / 32, a % 32) : 32'hDEAD_BEEF;
      for (int i = 0; i < 25; i++) coeff_reg[i] = 16'h0;
      bus_if.bram_rdata = '0;
      test_reset();
      test_basic_load();
      test_frame_busy();
      test_cpu_contention();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
